// File: rtl/kc_bus_pkg.sv
// Shared KC85 bus constants and the module-control FSM state type.
package kc_bus_pkg;

  localparam logic [7:0] PORT_MODCTRL = 8'h80;

  localparam int CB_EN = 0;
  localparam int CB_WE = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_HOLD  = 2'd1,
    ST_RD_DRIVE = 2'd2
  } modctrl_state_t;

endpackage

// File: rtl/kc_sync_edge.sv
// Synchroniser for an asynchronous active-low strobe, giving the synchronised
// active-high level and a one-CLK pulse on its assertion.
module kc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_n_i,
  output logic active_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] warm_q;
  logic              prev_n_q;
  logic              armed_q;

  // The chain comes out of reset showing "inactive" regardless of the real
  // input, so edges are only armed once a genuine post-reset inactive sample
  // has travelled through: a strobe held across reset release is not an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '1;
      warm_q   <= '0;
      prev_n_q <= 1'b1;
      armed_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[STAGES-2:0], strobe_n_i};
      warm_q   <= {warm_q[STAGES-2:0], 1'b1};
      prev_n_q <= sync_q[STAGES-1];
      armed_q  <= armed_q | (warm_q[STAGES-1] & sync_q[STAGES-1]);
    end
  end

  assign active_o = ~sync_q[STAGES-1];
  assign rise_o   = armed_q & prev_n_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/kc_modctrl_reg.sv
// KC85 module control-byte register: snoops OUT/IN (80h) for its slot, holds
// the control byte, returns the module ID and decodes the RAM select.
module kc_modctrl_reg
  import kc_bus_pkg::*;
#(
  parameter logic [7:0] SLOT        = 8'h08,
  parameter logic [7:0] MODULE_ID   = 8'hF6,
  parameter int         BASE_BITS   = 2,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IORQ_N,
  input  logic        MREQ_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic        M1_N,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  output logic [7:0]  CTRL,
  output logic        MEM_CS,
  output logic        MEM_WE
);

  modctrl_state_t state_q, state_d;
  logic [7:0]     ctrl_q, ctrl_d;
  logic [7:0]     dout_q, dout_d;
  logic           doe_q, doe_d;

  logic io_wr_n, io_rd_n;
  logic wr_active, wr_rise;
  logic rd_active, rd_rise;
  logic addr_match;

  // M1_N low marks interrupt acknowledge, which must never look like port I/O.
  assign io_wr_n = IORQ_N | WR_N | ~M1_N;
  assign io_rd_n = IORQ_N | RD_N | ~M1_N;

  kc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk_i      (CLK),
    .rst_i      (RST),
    .strobe_n_i (io_wr_n),
    .active_o   (wr_active),
    .rise_o     (wr_rise)
  );

  kc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk_i      (CLK),
    .rst_i      (RST),
    .strobe_n_i (io_rd_n),
    .active_o   (rd_active),
    .rise_o     (rd_rise)
  );

  assign addr_match = (A[7:0] == PORT_MODCTRL) && (A[15:8] == SLOT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ctrl_q  <= 8'h00;
      dout_q  <= 8'h00;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
    end
  end

  // Write has priority over a simultaneous read; a held strobe never re-arms.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_rise && addr_match) begin
          state_d = ST_WR_HOLD;
        end else if (rd_rise && !wr_active && addr_match) begin
          state_d = ST_RD_DRIVE;
        end
      end
      ST_WR_HOLD: begin
        if (!wr_active) state_d = ST_IDLE;
      end
      ST_RD_DRIVE: begin
        if (!rd_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    dout_d = 8'h00;
    doe_d  = 1'b0;
    if (state_q == ST_IDLE && state_d == ST_WR_HOLD) begin
      ctrl_d = D_IN;
    end
    if (state_d == ST_RD_DRIVE) begin
      dout_d = MODULE_ID;
      doe_d  = 1'b1;
    end
  end

  assign CTRL   = ctrl_q;
  assign D_OUT  = dout_q;
  assign D_OE   = doe_q;

  assign MEM_CS = ctrl_q[CB_EN] & ~MREQ_N &
                  (A[15:16-BASE_BITS] == ctrl_q[7:8-BASE_BITS]);
  assign MEM_WE = MEM_CS & ctrl_q[CB_WE] & ~WR_N;

endmodule

// File: tb/tb_kc_modctrl_reg.sv
// Bench for kc_modctrl_reg with default parameters (SLOT 08h, ID F6h, 2 base bits).
module tb_kc_modctrl_reg;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IORQ_N, MREQ_N, RD_N, WR_N, M1_N;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  CTRL;
  logic        MEM_CS, MEM_WE;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  ctrl_model;
  logic [7:0]  exp_v;

  kc_modctrl_reg dut (
    .CLK    (CLK),
    .RST    (RST),
    .IORQ_N (IORQ_N),
    .MREQ_N (MREQ_N),
    .RD_N   (RD_N),
    .WR_N   (WR_N),
    .M1_N   (M1_N),
    .A      (A),
    .D_IN   (D_IN),
    .D_OUT  (D_OUT),
    .D_OE   (D_OE),
    .CTRL   (CTRL),
    .MEM_CS (MEM_CS),
    .MEM_WE (MEM_WE)
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic bus_idle();
    IORQ_N = 1'b1; MREQ_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1; M1_N = 1'b1;
  endtask

  task automatic io_start(input logic [15:0] a, input logic [7:0] d, input logic is_wr);
    @(posedge CLK); #2;
    A = a; D_IN = d; IORQ_N = 1'b0;
    if (is_wr) WR_N = 1'b0;
    else       RD_N = 1'b0;
  endtask

  task automatic io_end();
    @(posedge CLK); #2;
    IORQ_N = 1'b1; WR_N = 1'b1; RD_N = 1'b1;
    repeat (4) @(posedge CLK);
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    io_start(a, d, 1'b1);
    repeat (3) @(posedge CLK);
    io_end();
  endtask

  task automatic mem_drive(input logic [15:0] a, input logic wr);
    @(negedge CLK);
    A = a; MREQ_N = 1'b0; WR_N = ~wr;
    #2;
  endtask

  task automatic mem_idle();
    MREQ_N = 1'b1; WR_N = 1'b1;
    @(negedge CLK);
  endtask

  // Scenarios
  task automatic test_reset();
    RST = 1'b1; bus_idle(); A = 16'h0000; D_IN = 8'h00;
    #1;
    vectors++;
    if (CTRL !== 8'h00) begin miscompares++; $display("FAIL reset_ctrl: got %h expected 00", CTRL); end
    vectors++;
    if (D_OE !== 1'b0 || D_OUT !== 8'h00) begin
      miscompares++; $display("FAIL reset_dout: got oe=%b d=%h expected oe=0 d=00", D_OE, D_OUT);
    end
    vectors++;
    if (MEM_CS !== 1'b0) begin miscompares++; $display("FAIL reset_cs: got %b expected 0", MEM_CS); end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    ctrl_model = 8'h00;
  endtask

  task automatic test_write();
    exp_q.push_back(8'hC3);
    io_start(16'h0880, 8'hC3, 1'b1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (CTRL !== ctrl_model) begin
      miscompares++; $display("FAIL wr_latency_early: got %h expected %h", CTRL, ctrl_model);
    end
    @(posedge CLK); @(negedge CLK);
    exp_v = exp_q.pop_front();
    vectors++;
    if (CTRL !== exp_v) begin
      miscompares++; $display("FAIL wr_latency_exact: got %h expected %h", CTRL, exp_v);
    end
    ctrl_model = exp_v;
    io_end();

    mem_drive(16'hC123, 1'b0);
    vectors++;
    if (MEM_CS !== 1'b1 || MEM_WE !== 1'b0) begin
      miscompares++; $display("FAIL mem_rd_C123: got cs=%b we=%b expected cs=1 we=0", MEM_CS, MEM_WE);
    end
    mem_drive(16'hC000, 1'b1);
    vectors++;
    if (MEM_CS !== 1'b1 || MEM_WE !== 1'b1) begin
      miscompares++; $display("FAIL mem_wr_C000: got cs=%b we=%b expected cs=1 we=1", MEM_CS, MEM_WE);
    end
    mem_drive(16'h8000, 1'b1);
    vectors++;
    if (MEM_CS !== 1'b0 || MEM_WE !== 1'b0) begin
      miscompares++; $display("FAIL mem_8000: got cs=%b we=%b expected cs=0 we=0", MEM_CS, MEM_WE);
    end
    mem_idle();
  endtask

  task automatic test_wrong_slot();
    logic seen;
    exp_q.push_back(ctrl_model);
    io_write(16'h0780, 8'hFF);
    @(negedge CLK);
    exp_v = exp_q.pop_front();
    vectors++;
    if (CTRL !== exp_v) begin
      miscompares++; $display("FAIL wrong_slot_wr: got %h expected %h", CTRL, exp_v);
    end
    seen = 1'b0;
    io_start(16'h0780, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (D_OE !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL wrong_slot_rd: got oe=1 expected oe=0"); end
    io_end();
  endtask

  task automatic test_readback();
    io_start(16'h0880, 8'h00, 1'b0);
    exp_q.push_back(8'hF6);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (D_OE === 1'b1) break;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (D_OE !== 1'b1 || D_OUT !== exp_v) begin
      miscompares++; $display("FAIL rd_assert: got oe=%b d=%h expected oe=1 d=%h", D_OE, D_OUT, exp_v);
    end
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (D_OE !== 1'b1 || CTRL !== ctrl_model) begin
      miscompares++; $display("FAIL rd_hold: got oe=%b ctrl=%h expected oe=1 ctrl=%h", D_OE, CTRL, ctrl_model);
    end
    @(posedge CLK); #2;
    IORQ_N = 1'b1; RD_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (D_OE === 1'b0) break;
    end
    vectors++;
    if (D_OE !== 1'b0 || D_OUT !== 8'h00) begin
      miscompares++; $display("FAIL rd_release: got oe=%b d=%h expected oe=0 d=00", D_OE, D_OUT);
    end
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_write_protect();
    exp_q.push_back(8'h41);
    io_write(16'h0880, 8'h41);
    @(negedge CLK);
    exp_v = exp_q.pop_front();
    vectors++;
    if (CTRL !== exp_v) begin miscompares++; $display("FAIL wp_ctrl: got %h expected %h", CTRL, exp_v); end
    ctrl_model = exp_v;
    mem_drive(16'h4000, 1'b1);
    vectors++;
    if (MEM_CS !== 1'b1 || MEM_WE !== 1'b0) begin
      miscompares++; $display("FAIL wp_4000: got cs=%b we=%b expected cs=1 we=0", MEM_CS, MEM_WE);
    end
    mem_drive(16'hC000, 1'b0);
    vectors++;
    if (MEM_CS !== 1'b0) begin miscompares++; $display("FAIL wp_C000: got cs=%b expected 0", MEM_CS); end
    mem_idle();
  endtask

  task automatic test_long_strobe();
    exp_q.push_back(8'h5A);
    io_start(16'h0880, 8'h5A, 1'b1);
    repeat (5) @(posedge CLK);
    #2 D_IN = 8'hA5;
    repeat (15) @(posedge CLK);
    @(negedge CLK);
    exp_v = exp_q.pop_front();
    vectors++;
    if (CTRL !== exp_v) begin miscompares++; $display("FAIL long_hold: got %h expected %h", CTRL, exp_v); end
    io_end();
    vectors++;
    if (CTRL !== exp_v) begin miscompares++; $display("FAIL long_release: got %h expected %h", CTRL, exp_v); end
    ctrl_model = exp_v;
  endtask

  task automatic test_inta();
    logic seen;
    @(posedge CLK); #2;
    A = 16'h0880; D_IN = 8'h3C; M1_N = 1'b0; IORQ_N = 1'b0; WR_N = 1'b0;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (CTRL !== ctrl_model) begin
      miscompares++; $display("FAIL inta_wr: got %h expected %h", CTRL, ctrl_model);
    end
    WR_N = 1'b1; RD_N = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (D_OE !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL inta_rd: got oe=1 expected oe=0"); end
    bus_idle();
    repeat (4) @(posedge CLK);
  endtask

  task automatic test_both_strobes();
    logic seen;
    exp_q.push_back(8'h99);
    @(posedge CLK); #2;
    A = 16'h0880; D_IN = 8'h99; IORQ_N = 1'b0; WR_N = 1'b0; RD_N = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      if (D_OE !== 1'b0) seen = 1'b1;
    end
    exp_v = exp_q.pop_front();
    vectors++;
    if (CTRL !== exp_v || seen !== 1'b0) begin
      miscompares++; $display("FAIL both_strobes: got ctrl=%h oe_seen=%b expected ctrl=%h oe_seen=0", CTRL, seen, exp_v);
    end
    ctrl_model = exp_v;
    io_end();
  endtask

  task automatic test_back_to_back();
    logic [7:0] d, slot;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      slot = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(9, 255)) : 8'h08;
      exp_q.push_back((slot == 8'h08) ? d : ctrl_model);
      io_write({slot, 8'h80}, d);
      @(negedge CLK);
      exp_v = exp_q.pop_front();
      vectors++;
      if (CTRL !== exp_v) begin
        miscompares++; $display("FAIL b2b[%0d] slot=%h d=%h: got %h expected %h", i, slot, d, CTRL, exp_v);
      end
      ctrl_model = exp_v;
    end
  endtask

  task automatic test_reset_midrun();
    io_write(16'h0880, 8'hC3);
    ctrl_model = 8'hC3;
    mem_drive(16'hC123, 1'b0);
    vectors++;
    if (MEM_CS !== 1'b1) begin miscompares++; $display("FAIL pre_reset_cs: got %b expected 1", MEM_CS); end
    #1 RST = 1'b1;
    #1;
    vectors++;
    if (CTRL !== 8'h00 || MEM_CS !== 1'b0 || D_OE !== 1'b0) begin
      miscompares++; $display("FAIL async_reset: got ctrl=%h cs=%b oe=%b expected 00/0/0", CTRL, MEM_CS, D_OE);
    end
    ctrl_model = 8'h00;
    mem_idle();
    @(negedge CLK); RST = 1'b0;
    repeat (4) @(posedge CLK);

    io_start(16'h0880, 8'h00, 1'b0);
    repeat (4) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (D_OE !== 1'b0 || D_OUT !== 8'h00) begin
      miscompares++; $display("FAIL reset_abort_rd: got oe=%b d=%h expected oe=0 d=00", D_OE, D_OUT);
    end
    RD_N = 1'b1; WR_N = 1'b0; D_IN = 8'hAA;
    @(negedge CLK); RST = 1'b0;
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    vectors++;
    if (CTRL !== ctrl_model) begin
      miscompares++; $display("FAIL held_wr_after_reset: got %h expected %h", CTRL, ctrl_model);
    end
    io_end();
    exp_q.push_back(8'h81);
    io_write(16'h0880, 8'h81);
    @(negedge CLK);
    exp_v = exp_q.pop_front();
    vectors++;
    if (CTRL !== exp_v) begin miscompares++; $display("FAIL post_reset_wr: got %h expected %h", CTRL, exp_v); end
    ctrl_model = exp_v;
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_slot();
    test_readback();
    test_write_protect();
    test_long_strobe();
    test_inta();
    test_both_strobes();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
